saturation_scheduler: RTL and testbench

- Time-multiplexes one limit-and-clip datapath across NUM_CH sample streams (e.g. per-axis PID outputs before the DAC).
- Round-robin arbitration over valid/ready inputs; per-channel programmable min/max limits; registered output with channel tag and saturation flag.
- Keeps per-channel sticky saturation flags and saturating event counters for the control host.

---
 rtl/sat_sched_pkg.sv | 39 +++
 rtl/saturation_scheduler_rr_arbiter.sv | 37 +++
 rtl/saturation_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_saturation_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_sched_pkg.sv
// Shared constants and helpers for the saturation scheduler.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package sat_sched_pkg;

    // Default sample width; the top can override it through its own parameter.
    localparam int DEF_DATA_WIDTH = 16;

    // Ceiling log2, used for the arbiter index width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Largest positive value of a signed 'width'-bit number (width <= 32).
    function automatic logic [31:0] lim_max(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Most negative value of a signed 'width'-bit number. Only the low
    // 'width' bits are meaningful; callers size-cast the result.
    function automatic logic [31:0] lim_min(input int width);
        return 32'd1 << (width - 1);
    endfunction

    // Increment an unsigned 'width'-bit counter, holding at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (v == mask) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/saturation_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after 'ptr'.
// Latency: purely combinational.
// Backpressure: 'en' low forces an all-zero grant.
// Ports: req (requests), ptr (last granted index), en (grant allowed),
//        gnt (one-hot grant), idx (binary index of the granted channel).
module rr_arbiter
    import sat_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] c_idx;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c_idx = '0;
        // Search ptr+1, ptr+2, ... wrapping; ptr itself is visited last.
        for (int i = 1; i <= NUM_CH; i++) begin
            c_idx = IDX_W'((int'(ptr) + i) % NUM_CH);
            if (en && !found && req[c_idx]) begin
                gnt[c_idx] = 1'b1;
                idx        = c_idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/saturation_scheduler.sv
// Shared limit-and-clip datapath time-multiplexed over NUM_CH sample streams.
// Latency: 1 cycle (sample accepted in cycle N is on out_* in cycle N+1).
// Backpressure: in_ready all-zero while the output register is full and out_ready=0.
// Ports: in_valid/in_data/in_ready (per-channel samples), out_valid/out_ready/
//        out_data/out_ch/out_sat (clipped result), cfg_we/cfg_ch/cfg_max/cfg_min/
//        cfg_err (limit programming), sat_clear/sat_sticky/cnt_sel/cnt_value (stats).
module saturation_scheduler
    import sat_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_sat,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [DATA_WIDTH-1:0]        cfg_max,
    input  logic [DATA_WIDTH-1:0]        cfg_min,
    output logic                         cfg_err,
    input  logic                         sat_clear,
    output logic [NUM_CH-1:0]            sat_sticky,
    input  logic [CH_W-1:0]              cnt_sel,
    output logic [CNT_WIDTH-1:0]         cnt_value
);

    localparam logic [DATA_WIDTH-1:0] LIM_MAX = DATA_WIDTH'(lim_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] LIM_MIN = DATA_WIDTH'(lim_min(DATA_WIDTH));

    // State
    logic [CH_W-1:0]       ptr_q,       ptr_d;
    logic                  ptr_vld_q,   ptr_vld_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]       out_ch_q,    out_ch_d;
    logic                  out_sat_q,   out_sat_d;
    logic                  cfg_err_q,   cfg_err_d;
    logic [NUM_CH-1:0]     sticky_q,    sticky_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
    logic [DATA_WIDTH-1:0] max_q [NUM_CH];
    logic [DATA_WIDTH-1:0] max_d [NUM_CH];
    logic [DATA_WIDTH-1:0] min_q [NUM_CH];
    logic [DATA_WIDTH-1:0] min_d [NUM_CH];

    // Arbitration
    logic                  out_free;
    logic [CH_W-1:0]       arb_ptr;
    logic [NUM_CH-1:0]     grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  accept;

    // Datapath
    logic signed [DATA_WIDTH-1:0] x_s, max_s, min_s, clip_s;
    logic                         clip_sat;
    logic                         cfg_bad;

    assign out_free = !out_valid_q || out_ready;

    // The pointer holds the last granted channel; until the first grant after
    // reset there is none, so present NUM_CH-1 to make channel 0 searched first.
    assign arb_ptr = ptr_vld_q ? ptr_q : CH_W'(NUM_CH - 1);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_arb (
        .req (in_valid),
        .ptr (arb_ptr),
        .en  (out_free),
        .gnt (grant),
        .idx (grant_idx)
    );

    assign accept   = |grant;
    assign in_ready = grant;

    // Select the granted sample and that channel's current (pre-write) limits.
    always_comb begin
        x_s   = '0;
        max_s = '0;
        min_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_idx == CH_W'(k)) begin
                x_s   = $signed(in_data[k*DATA_WIDTH +: DATA_WIDTH]);
                max_s = $signed(max_q[k]);
                min_s = $signed(min_q[k]);
            end
        end
    end

    always_comb begin
        clip_s   = x_s;
        clip_sat = 1'b0;
        if (x_s > max_s) begin
            clip_s   = max_s;
            clip_sat = 1'b1;
        end else if (x_s < min_s) begin
            clip_s   = min_s;
            clip_sat = 1'b1;
        end
    end

    assign cfg_bad = cfg_we &&
                     (($signed(cfg_min) > $signed(cfg_max)) || (int'(cfg_ch) >= NUM_CH));

    always_comb begin
        ptr_d       = ptr_q;
        ptr_vld_d   = ptr_vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_sat_d   = out_sat_q;
        cfg_err_d   = cfg_bad;
        sticky_d    = sticky_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            max_d[k] = max_q[k];
            min_d[k] = min_q[k];
        end

        // Output register: load on accept, otherwise drain when downstream takes it.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = clip_s;
            out_ch_d    = grant_idx;
            out_sat_d   = clip_sat;
            ptr_d       = grant_idx;
            ptr_vld_d   = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_we && !cfg_bad && (int'(cfg_ch) == k)) begin
                max_d[k] = cfg_max;
                min_d[k] = cfg_min;
            end

            // Clear first, then let a same-cycle saturation event override it.
            if (sat_clear) begin
                cnt_d[k]    = '0;
                sticky_d[k] = 1'b0;
            end
            if (accept && clip_sat && (grant_idx == CH_W'(k))) begin
                sticky_d[k] = 1'b1;
                cnt_d[k]    = sat_clear ? CNT_WIDTH'(1)
                                        : CNT_WIDTH'(sat_inc(32'(cnt_q[k]), CNT_WIDTH));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            ptr_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            sticky_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
                max_q[k] <= LIM_MAX;
                min_q[k] <= LIM_MIN;
            end
        end else begin
            ptr_q       <= ptr_d;
            ptr_vld_q   <= ptr_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_sat_q   <= out_sat_d;
            cfg_err_q   <= cfg_err_d;
            sticky_q    <= sticky_d;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
                max_q[k] <= max_d[k];
                min_q[k] <= min_d[k];
            end
        end
    end

    // Host counter read-back; out-of-range selects read as zero.
    always_comb begin
        cnt_value = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(cnt_sel) == k) begin
                cnt_value = cnt_q[k];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_sat    = out_sat_q;
    assign cfg_err    = cfg_err_q;
    assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_saturation_scheduler.sv
// Directed self-checking bench for saturation_scheduler (DATA_WIDTH=16, NUM_CH=4).
// Latency: n/a.
// Backpressure: exercised by holding out_ready low with a sample pending.
module tb_saturation_scheduler;

    localparam int DW  = 16;
    localparam int NC  = 4;
    localparam int CW  = 2;
    localparam int CNW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    in_valid;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]    in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_ch;
    logic             out_sat;
    logic             cfg_we;
    logic [CW-1:0]    cfg_ch;
    logic [DW-1:0]    cfg_max;
    logic [DW-1:0]    cfg_min;
    logic             cfg_err;
    logic             sat_clear;
    logic [NC-1:0]    sat_sticky;
    logic [CW-1:0]    cnt_sel;
    logic [CNW-1:0]   cnt_value;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] rr_dat [NC] = '{16'h0010, 16'h0011, 16'h05DC, 16'h0013};

    saturation_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .CH_W       (CW),
        .CNT_WIDTH  (CNW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_sat    (out_sat),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_max    (cfg_max),
        .cfg_min    (cfg_min),
        .cfg_err    (cfg_err),
        .sat_clear  (sat_clear),
        .sat_sticky (sat_sticky),
        .cnt_sel    (cnt_sel),
        .cnt_value  (cnt_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_max   = '0;
        cfg_min   = '0;
        sat_clear = 1'b0;
        cnt_sel   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_sticky", sat_sticky, 0);
        chk("rst_cnt0", cnt_value, 0);
        chk("rst_in_ready", in_ready, 0);

        // Single ch1 sample with pass-through limits
        in_valid = 4'b0010;
        in_data[1*DW +: DW] = 16'h7000;
        #1;
        chk("ch1_in_ready", in_ready, 4'b0010);
        tick();
        in_valid = '0;
        chk("ch1_out_valid", out_valid, 1);
        chk("ch1_out_data", out_data, 16'h7000);
        chk("ch1_out_ch", out_ch, 1);
        chk("ch1_out_sat", out_sat, 0);
        tick();
        chk("ch1_drained", out_valid, 0);

        // ch2 limits +/-1000, then clip high and low
        cfg_we  = 1'b1;
        cfg_ch  = 2'd2;
        cfg_max = 16'h03E8;
        cfg_min = 16'hFC18;
        tick();
        cfg_we = 1'b0;
        chk("cfg2_err", cfg_err, 0);
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 16'h05DC;
        tick();
        chk("ch2_hi_data", out_data, 16'h03E8);
        chk("ch2_hi_sat", out_sat, 1);
        chk("ch2_hi_ch", out_ch, 2);
        in_data[2*DW +: DW] = 16'hF448;
        tick();
        in_valid = '0;
        chk("ch2_lo_data", out_data, 16'hFC18);
        chk("ch2_lo_sat", out_sat, 1);
        tick();
        cnt_sel = 2'd2;
        #1;
        chk("ch2_sticky", sat_sticky, 4'b0100);
        chk("ch2_cnt", cnt_value, 2);

        // Reset with a sample in flight
        in_valid  = 4'b0100;
        in_data[2*DW +: DW] = 16'h05DC;
        out_ready = 1'b0;
        tick();
        in_valid = '0;
        chk("inflight_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cnt2", cnt_value, 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;

        // All channels valid: round-robin 0,1,2,3,0,1; ch2 limits back to pass-through
        in_valid = 4'b1111;
        in_data  = {16'h0013, 16'h05DC, 16'h0011, 16'h0010};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_ready_%0d", i), in_ready, 32'(1 << (i % 4)));
            tick();
            chk($sformatf("rr_ch_%0d", i), out_ch, i % 4);
            chk($sformatf("rr_data_%0d", i), out_data, rr_dat[i % 4]);
            chk($sformatf("rr_sat_%0d", i), out_sat, 0);
        end

        // Backpressure: ch1 sample held for 5 cycles
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid_%0d", i), out_valid, 1);
            chk($sformatf("bp_ch_%0d", i), out_ch, 1);
            chk($sformatf("bp_data_%0d", i), out_data, 16'h0011);
            chk($sformatf("bp_ready_%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0100);
        tick();
        in_valid = '0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_ch", out_ch, 2);
        chk("bp_next_data", out_data, 16'h05DC);
        tick();
        chk("bp_drained", out_valid, 0);

        // Rejected write: min > max
        cfg_we  = 1'b1;
        cfg_ch  = 2'd0;
        cfg_max = 16'd5;
        cfg_min = 16'd10;
        tick();
        cfg_we = 1'b0;
        chk("cfg_bad_err", cfg_err, 1);
        in_valid = 4'b0001;
        in_data[0*DW +: DW] = 16'h7FFF;
        tick();
        in_valid = '0;
        chk("cfg_bad_err_gone", cfg_err, 0);
        chk("cfg_bad_data", out_data, 16'h7FFF);
        chk("cfg_bad_sat", out_sat, 0);

        // Same-cycle write and sample: old limits apply to this sample
        cfg_we  = 1'b1;
        cfg_ch  = 2'd0;
        cfg_max = 16'h0064;
        cfg_min = 16'hFF9C;
        in_valid = 4'b0001;
        in_data[0*DW +: DW] = 16'h01F4;
        tick();
        cfg_we = 1'b0;
        chk("samecyc_err", cfg_err, 0);
        chk("samecyc_data", out_data, 16'h01F4);
        chk("samecyc_sat", out_sat, 0);
        tick();
        in_valid = '0;
        chk("newlim_data", out_data, 16'h0064);
        chk("newlim_sat", out_sat, 1);

        // ch3 counter saturation
        cfg_we  = 1'b1;
        cfg_ch  = 2'd3;
        cfg_max = 16'd0;
        cfg_min = 16'd0;
        tick();
        cfg_we   = 1'b0;
        cnt_sel  = 2'd3;
        in_valid = 4'b1000;
        in_data[3*DW +: DW] = 16'h0001;
        repeat (65534) tick();
        chk("cnt3_fffe", cnt_value, 16'hFFFE);
        repeat (70000 - 65534) tick();
        in_valid = '0;
        chk("cnt3_hold", cnt_value, 16'hFFFF);
        chk("cnt3_out_data", out_data, 0);
        chk("cnt3_out_sat", out_sat, 1);
        chk("cnt3_sticky", sat_sticky, 4'b1001);
        cnt_sel = 2'd0;
        #1;
        chk("cnt0_val", cnt_value, 1);

        // sat_clear coincident with a ch3 clip event
        in_valid  = 4'b1000;
        sat_clear = 1'b1;
        tick();
        in_valid  = '0;
        sat_clear = 1'b0;
        cnt_sel   = 2'd3;
        #1;
        chk("clr_evt_cnt3", cnt_value, 1);
        chk("clr_evt_sticky", sat_sticky, 4'b1000);
        cnt_sel = 2'd0;
        #1;
        chk("clr_evt_cnt0", cnt_value, 0);

        // Plain clear
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        cnt_sel   = 2'd3;
        #1;
        chk("clr_cnt3", cnt_value, 0);
        chk("clr_sticky", sat_sticky, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
